// File: rtl/hex_counter_pkg.sv
// hex_counter_pkg: shared widths and direction constants for the hex digit counter
package hex_counter_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'hF;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/hex_digit_counter_if.sv
// hex_digit_counter_if: button, switch and display-side signals of the hex digit counter
interface hex_digit_counter_if;
  import hex_counter_pkg::*;
  logic load_btn_n;
  logic step_btn_n;
  logic [DIGIT_W-1:0] load_val;
  logic run;
  logic up;
  logic [DIGIT_W-1:0] digit;
  logic wrap;
  logic tick;
  modport master(output load_btn_n, step_btn_n, load_val, run, up, input digit, wrap, tick);
  modport slave(input load_btn_n, step_btn_n, load_val, run, up, output digit, wrap, tick);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces an active-low button, pulsing press on each accepted fall
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic btn_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1, sync2, level;
  logic [CW-1:0] cnt;
  logic accept;
  assign accept = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      cnt   <= (sync2 == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? sync2 : level;
      press <= accept && !sync2;
    end
  end
endmodule

// File: rtl/hex_digit_counter.sv
// hex_digit_counter: up/down hex digit with prescaled auto-count, debounced step/load buttons and wrap pulse
module hex_digit_counter
  import hex_counter_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic CLOCK_50,
  input logic KEY0,
  hex_digit_counter_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  logic load_press, step_press;
  logic [PW-1:0] pre;
  logic run_q, tick_q, wrap_q, wrap_n, adv;
  logic [DIGIT_W-1:0] digit_q, digit_n;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .btn_n(bus.load_btn_n), .press(load_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .btn_n(bus.step_btn_n), .press(step_press)
  );
  always_comb begin
    adv     = step_press || tick_q;
    digit_n = load_press ? bus.load_val :
              adv ? (bus.up == DIR_UP ? digit_q + 4'd1 : digit_q - 4'd1) : digit_q;
    wrap_n  = !load_press && adv && (bus.up == DIR_UP ? digit_q == DIGIT_MAX : digit_q == '0);
  end
  // the first sampled-high cycle holds the prescaler at 0, so a fresh run waits a full period plus one
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      run_q   <= 1'b0;
      pre     <= '0;
      tick_q  <= 1'b0;
      digit_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      run_q   <= bus.run;
      pre     <= (!bus.run || !run_q || pre == PMAX) ? '0 : pre + 1'b1;
      tick_q  <= bus.run && run_q && pre == PMAX;
      digit_q <= digit_n;
      wrap_q  <= wrap_n;
    end
  end
  assign bus.digit = digit_q;
  assign bus.wrap  = wrap_q;
  assign bus.tick  = tick_q;
endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter: randomized buttons/run/up against a cycle-level behavioural model
module tb_hex_digit_counter;
  localparam int CLK_DIV = 4;
  localparam int DB = 3;
  logic CLOCK_50 = 1'b0;
  logic KEY0 = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  hex_digit_counter_if bus();
  hex_digit_counter #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .bus(bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  int m_digit, m_run_len;
  logic m_wrap, m_tick;
  logic h1[2], h2[2], lvl[2], m_press[2];
  int dc[2];
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_digit = 0;
    m_wrap = 1'b0;
    m_tick = 1'b0;
    m_run_len = 0;
    for (int b = 0; b < 2; b++) begin
      h1[b] = 1'b1;
      h2[b] = 1'b1;
      lvl[b] = 1'b1;
      dc[b] = 0;
      m_press[b] = 1'b0;
    end
  endtask
  // one clock edge: effects of last cycle's pulses, then new pulses from this edge's samples
  task automatic model_edge();
    logic raw[2];
    logic synced;
    raw[0] = bus.load_btn_n;
    raw[1] = bus.step_btn_n;
    if (m_press[0]) begin
      m_digit = int'(bus.load_val);
      m_wrap = 1'b0;
    end else if (m_press[1] || m_tick) begin
      m_wrap = bus.up ? (m_digit == 15) : (m_digit == 0);
      m_digit = (m_digit + (bus.up ? 1 : 15)) % 16;
    end else m_wrap = 1'b0;
    for (int b = 0; b < 2; b++) begin
      synced = h2[b];
      h2[b] = h1[b];
      h1[b] = raw[b];
      m_press[b] = 1'b0;
      if (synced != lvl[b]) begin
        dc[b]++;
        if (dc[b] == DB) begin
          lvl[b] = synced;
          dc[b] = 0;
          m_press[b] = !synced;
        end
      end else dc[b] = 0;
    end
    m_run_len = bus.run ? m_run_len + 1 : 0;
    m_tick = bus.run && m_run_len > CLK_DIV && (m_run_len - 1) % CLK_DIV == 0;
  endtask
  task automatic cyc(input logic lb, input logic sb, input logic [3:0] lv, input logic r, input logic u);
    bus.load_btn_n = lb;
    bus.step_btn_n = sb;
    bus.load_val = lv;
    bus.run = r;
    bus.up = u;
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    chk("digit", int'(bus.digit), m_digit);
    chk("wrap", int'(bus.wrap), int'(m_wrap));
    chk("tick", int'(bus.tick), int'(m_tick));
  endtask
  task automatic pulse_reset();
    #2 KEY0 = 1'b0;
    #1;
    chk("rst_digit", int'(bus.digit), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    chk("rst_tick", int'(bus.tick), 0);
    model_reset();
    #1 KEY0 = 1'b1;
  endtask
  initial begin
    logic lb, sb, r, u;
    int hl, hs, d0;
    bus.load_btn_n = 1'b1;
    bus.step_btn_n = 1'b1;
    bus.load_val = 4'h0;
    bus.run = 1'b0;
    bus.up = 1'b1;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    chk("reset_digit", int'(bus.digit), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    chk("reset_tick", int'(bus.tick), 0);
    KEY0 = 1'b1;
    repeat (70) cyc(1, 1, 4'h0, 1, 1);
    pulse_reset();
    repeat (12) cyc(1, 1, 4'h0, 1, 1);
    repeat (6) cyc(0, 1, 4'h0, 0, 1);
    repeat (6) cyc(1, 1, 4'h0, 0, 1);
    chk("load_zero", int'(bus.digit), 0);
    repeat (6) cyc(1, 0, 4'h0, 0, 0);
    repeat (6) cyc(1, 1, 4'h0, 0, 0);
    chk("down_wrap", int'(bus.digit), 15);
    d0 = int'(bus.digit);
    repeat (2) cyc(1, 0, 4'h0, 0, 1);
    repeat (10) cyc(1, 1, 4'h0, 0, 1);
    chk("glitch", int'(bus.digit), d0);
    repeat (10) cyc(1, 0, 4'h0, 0, 1);
    repeat (10) cyc(1, 1, 4'h0, 0, 1);
    chk("one_step", int'(bus.digit), (d0 + 1) % 16);
    repeat (20) cyc(1, 1, 4'h0, 0, 1);
    chk("run_off_hold", int'(bus.digit), (d0 + 1) % 16);
    lb = 1'b1; sb = 1'b1; r = 1'b1; u = 1'b1; hl = 20; hs = 5;
    for (int i = 0; i < 3000; i++) begin
      if (--hl == 0) begin
        lb = !lb;
        hl = lb ? $urandom_range(8, 60) : $urandom_range(1, 8);
      end
      if (--hs == 0) begin
        sb = !sb;
        hs = $urandom_range(1, 9);
      end
      if ($urandom_range(0, 59) == 0) r = !r;
      if ($urandom_range(0, 39) == 0) u = !u;
      cyc(lb, sb, 4'($urandom), r, u);
      if (i == 1500) pulse_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hex_digit_counter.md
# hex_digit_counter

Clocked source of the 4-bit hex digit that drives the board's seven-segment decoder (digit[3:0] connects straight to the decoder's SW[3:0] input).

- Counts up or down, one step per prescaled tick while running, or one step per debounced push-button press.
- Can be parallel-loaded from slide switches.
- Flags every 0xF↔0x0 wrap with a one-cycle pulse so digits can be chained later.

## Interface

Parameters:
- CLK_DIV, 50_000_000: clock cycles per auto-count tick (1 Hz at 50 MHz); ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: cycles a button level must differ from the debounced level before it is accepted (20 ms at 50 MHz); ≥ 1.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- KEY0  in  1  reset; asynchronous assert, active-low.
- load_btn_n  in  1  raw load push-button, active-low, asynchronous to CLOCK_50.
- step_btn_n  in  1  raw step push-button, active-low, asynchronous to CLOCK_50.
- load_val  in  4  value loaded on a load press (slide switches, treated as static).
- run  in  1  1 = auto-count on ticks; 0 = prescaler held at 0.
- up  in  1  1 = count up, 0 = count down; applies to ticks and steps.
- digit  out  4  current count, registered.
- wrap  out  1  one-cycle pulse when a count step crosses 0xF→0x0 (up) or 0x0→0xF (down).
- tick  out  1  one-cycle registered prescaler pulse.

## Operation

- **Reset** (KEY0 low, any time, including mid-debounce or mid-tick):
  - digit=0, wrap=0, tick=0.
  - Prescaler=0.
  - Synchronizers and debounced levels=1 (released); debounce counters=0.
  - Takes effect immediately, not on the next edge.
- **Button path** (one instance per button):
  - Two-flop synchronizer.
  - Debounce counter:
    - Clears whenever the synchronized level equals the debounced level.
    - Otherwise increments.
    - On reaching DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - press pulse: one cycle, registered, on each debounced 1→0 transition only. Release generates nothing.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- **Prescaler**:
  - run=1: counts 0..CLK_DIV-1 and wraps; tick asserted for the cycle after the prescaler value CLK_DIV-1.
  - run=0: prescaler forced to 0, tick=0.
- **Count update priority**, evaluated each cycle:
  1. load press: digit←load_val, wrap=0.
  2. step press or tick (either or both in the same cycle): exactly one step in the direction of up.
  3. Otherwise: hold.
- **Arithmetic**: 4-bit modulo-16. wrap is asserted in the same cycle digit takes the wrapped value. A load never asserts wrap.
- A step press counts whether or not run is set.

## Timing

- **Button latency**:
  - Raw level change before edge 0 → synchronized at edge 2 → debounced level changes at edge 2+DEBOUNCE_CYCLES.
  - press high in the following cycle.
  - digit updates at edge 3+DEBOUNCE_CYCLES (±1 cycle from sampling alignment).
- **Tick**:
  - Period is exactly CLK_DIV cycles while run stays 1.
  - First tick is CLK_DIV+1 cycles after run is first sampled high.
  - digit updates on the edge following the tick cycle.
- **run dropping** mid-period discards the partial count. Raising run again restarts a full period.
- **Outputs** digit, wrap and tick are all registered; there is no combinational path from inputs to outputs.

## Structure

- Package hex_counter_pkg:
  - DIGIT_W=4, DIGIT_MAX=4'hF.
  - Direction constants DIR_UP=1'b1, DIR_DOWN=1'b0.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports CLOCK_50, KEY0, btn_n, press). Instantiated twice.
- Top level holds the prescaler, priority mux and digit/wrap registers.

## Test plan

All scenarios use CLK_DIV=4, DEBOUNCE_CYCLES=3.

- Reset mid-operation: run=1, up=1, digit=5; pulse KEY0 low between edges → digit=0, wrap=0, tick=0 immediately; the next tick arrives a full period after release.
- Auto count up: run=1, up=1 from reset → digit=1,2,…,F,0 on successive ticks exactly 4 cycles apart; wrap high only in the cycle digit becomes 0.
- Down wrap: load_val=0 plus a load press, then up=0, step press → digit=F, wrap pulses once.
- Debounce: step_btn_n low for 2 cycles → no change. Low for 10 cycles → exactly one increment about 5-6 cycles after falling; release → no change.
- Simultaneous events: load press in the same cycle as a tick with load_val=9 → digit=9, no step, wrap=0. Step press coincident with a tick → digit advances by 1, not 2.
- run toggling: run=0 for 20 cycles → tick never asserts, digit holds. Step presses still count.
